// File: rtl/branch_exec_unit.sv
// Branch execution unit: decodes b/bc/bclr/bcctr, evaluates BO/BI conditions
// and owns LR, CTR and CR; each accepted instruction resolves one cycle later.
module branch_exec_unit #(
  parameter int addressWidth = 64,
  parameter int immWidth = 24,
  parameter logic [addressWidth-1:0] resetVector = '0,
  parameter int opcodeWidth = 6,
  parameter int xOpCodeWidth = 10
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    stall_i,
  input  logic                    valid_i,
  input  logic                    is64Bit_i,
  input  logic [opcodeWidth-1:0]  opCode_i,
  input  logic [xOpCodeWidth-1:0] xOpCode_i,
  input  logic [immWidth-1:0]     imm_i,
  input  logic [4:0]              bo_i,
  input  logic [4:0]              bi_i,
  input  logic                    aa_i,
  input  logic                    lk_i,
  input  logic [addressWidth-1:0] instructionAddress_i,
  input  logic                    crWrite_i,
  input  logic [31:0]             crData_i,
  input  logic                    lrWrite_i,
  input  logic                    ctrWrite_i,
  input  logic [addressWidth-1:0] sprData_i,
  output logic                    valid_o,
  output logic                    isBranching_o,
  output logic [addressWidth-1:0] PC_o,
  output logic [addressWidth-1:0] lr_o,
  output logic [addressWidth-1:0] ctr_o
);

  localparam logic [opcodeWidth-1:0]  OpB     = opcodeWidth'(18);
  localparam logic [opcodeWidth-1:0]  OpBc    = opcodeWidth'(16);
  localparam logic [opcodeWidth-1:0]  OpXl    = opcodeWidth'(19);
  localparam logic [xOpCodeWidth-1:0] XopBclr = xOpCodeWidth'(16);
  localparam logic [xOpCodeWidth-1:0] XopBctr = xOpCodeWidth'(528);

  // In 32-bit mode only the low word of an address is architecturally live.
  function automatic logic [addressWidth-1:0] mode_mask(
    input logic [addressWidth-1:0] value,
    input logic                    mode64
  );
    logic [addressWidth-1:0] keep;
    keep = mode64 ? '1 : addressWidth'(64'hFFFF_FFFF);
    return value & keep;
  endfunction

  logic                           is_b, is_bc, is_bclr, is_bcctr, is_branch;
  logic signed [addressWidth-1:0] disp_li, disp_bd, disp;
  logic [addressWidth-1:0]        cia_plus4, raw_target, target, ctr_dec, lr_link;
  logic                           ctr_dec_en, ctr_nz, ctr_ok, cr_bit, cond_ok, taken;

  logic [addressWidth-1:0] pc_p1, lr_q, ctr_q;
  logic [31:0]             cr_q;
  logic                    vld_p1, br_p1;

  // Stage 0: decode, condition evaluation and target formation.
  always_comb begin
    is_b      = (opCode_i == OpB);
    is_bc     = (opCode_i == OpBc);
    is_bclr   = (opCode_i == OpXl) && (xOpCode_i == XopBclr);
    is_bcctr  = (opCode_i == OpXl) && (xOpCode_i == XopBctr);
    is_branch = is_b | is_bc | is_bclr | is_bcctr;

    disp_li = {{(addressWidth-immWidth-2){imm_i[immWidth-1]}}, imm_i, 2'b00};
    disp_bd = {{(addressWidth-16){imm_i[13]}}, imm_i[13:0], 2'b00};
    disp    = is_b ? disp_li : disp_bd;

    cia_plus4 = instructionAddress_i + addressWidth'(4);
    lr_link   = mode_mask(cia_plus4, is64Bit_i);

    raw_target = aa_i ? disp : instructionAddress_i + disp;
    if (is_bclr)  raw_target = lr_q & ~addressWidth'(3);
    if (is_bcctr) raw_target = ctr_q & ~addressWidth'(3);
    target = mode_mask(raw_target, is64Bit_i);

    // bo_i[4] is BO0 (MSB first), so BO1/BO2/BO3 map to bo_i[3]/[2]/[1].
    ctr_dec    = ctr_q - addressWidth'(1);
    ctr_dec_en = (is_bc | is_bclr) & ~bo_i[2];
    ctr_nz     = is64Bit_i ? (|ctr_dec) : (|ctr_dec[31:0]);
    ctr_ok     = is_bcctr | bo_i[2] | (ctr_nz ^ bo_i[1]);
    cr_bit     = cr_q[5'd31 - bi_i];
    cond_ok    = bo_i[4] | (cr_bit == bo_i[3]);
    taken      = is_b | ((is_bc | is_bclr | is_bcctr) & ctr_ok & cond_ok);
  end

  // Stage 1: registered result and architectural state update.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      vld_p1 <= 1'b0;
      br_p1  <= 1'b0;
      pc_p1  <= resetVector;
      lr_q   <= '0;
      ctr_q  <= '0;
      cr_q   <= '0;
    end else if (stall_i) begin
      vld_p1 <= 1'b0;
      br_p1  <= 1'b0;
    end else begin
      vld_p1 <= valid_i;
      br_p1  <= valid_i & taken;
      if (valid_i) pc_p1 <= taken ? target : cia_plus4;
      if (crWrite_i) cr_q <= crData_i;
      if (valid_i && is_branch && lk_i) lr_q <= lr_link;
      else if (lrWrite_i)               lr_q <= sprData_i;
      if (valid_i && ctr_dec_en) ctr_q <= ctr_dec;
      else if (ctrWrite_i)       ctr_q <= sprData_i;
    end
  end

  assign valid_o       = vld_p1;
  assign isBranching_o = br_p1;
  assign PC_o          = pc_p1;
  assign lr_o          = lr_q;
  assign ctr_o         = ctr_q;

endmodule

// File: tb/tb_branch_exec_unit.sv
// Randomized scoreboard bench for branch_exec_unit with directed known-answer cases.
module tb_branch_exec_unit;

  localparam logic [63:0] RV = 64'h0000_0000_0000_1000;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        is64Bit_i = 1'b1;
  logic [5:0]  opCode_i = '0;
  logic [9:0]  xOpCode_i = '0;
  logic [23:0] imm_i = '0;
  logic [4:0]  bo_i = '0;
  logic [4:0]  bi_i = '0;
  logic        aa_i = 1'b0;
  logic        lk_i = 1'b0;
  logic [63:0] instructionAddress_i = '0;
  logic        crWrite_i = 1'b0;
  logic [31:0] crData_i = '0;
  logic        lrWrite_i = 1'b0;
  logic        ctrWrite_i = 1'b0;
  logic [63:0] sprData_i = '0;
  logic        valid_o, isBranching_o;
  logic [63:0] PC_o, lr_o, ctr_o;

  branch_exec_unit #(.addressWidth(64), .immWidth(24), .resetVector(RV),
                     .opcodeWidth(6), .xOpCodeWidth(10)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .stall_i(stall_i), .valid_i(valid_i),
    .is64Bit_i(is64Bit_i), .opCode_i(opCode_i), .xOpCode_i(xOpCode_i), .imm_i(imm_i),
    .bo_i(bo_i), .bi_i(bi_i), .aa_i(aa_i), .lk_i(lk_i),
    .instructionAddress_i(instructionAddress_i), .crWrite_i(crWrite_i),
    .crData_i(crData_i), .lrWrite_i(lrWrite_i), .ctrWrite_i(ctrWrite_i),
    .sprData_i(sprData_i), .valid_o(valid_o), .isBranching_o(isBranching_o),
    .PC_o(PC_o), .lr_o(lr_o), .ctr_o(ctr_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic        br;
    logic [63:0] pc;
    logic [63:0] lr;
    logic [63:0] ctr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  logic [63:0] m_lr, m_ctr, m_pc;
  logic [31:0] m_cr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clock_i) begin
    if (mon_en) begin
      if (valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(valid_o), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_branching", 64'(isBranching_o), 64'(e.br));
          chk("sb_pc", PC_o, e.pc);
          chk("sb_lr", lr_o, e.lr);
          chk("sb_ctr", ctr_o, e.ctr);
        end
      end else begin
        chk("idle_branching", 64'(isBranching_o), 64'd0);
      end
    end
  end

  // Reference model: applies the ISA rules to the model state, then one clock.
  task automatic cycle();
    exp_t        e;
    logic [63:0] cia, nia, tgt, ctrm1, new_lr, new_ctr;
    longint      sdisp;
    bit          is_b, is_bc, is_lr, is_cc, is_br, zero, ctr_ok, cond_ok, tk, dec;
    if (!stall_i) begin
      new_lr  = lrWrite_i  ? sprData_i : m_lr;
      new_ctr = ctrWrite_i ? sprData_i : m_ctr;
      if (valid_i) begin
        cia   = instructionAddress_i;
        nia   = cia + 64'd4;
        is_b  = (opCode_i == 6'd18);
        is_bc = (opCode_i == 6'd16);
        is_lr = (opCode_i == 6'd19) && (xOpCode_i == 10'd16);
        is_cc = (opCode_i == 6'd19) && (xOpCode_i == 10'd528);
        is_br = is_b || is_bc || is_lr || is_cc;
        if (is_b) sdisp = longint'($signed(imm_i)) * 4;
        else      sdisp = longint'($signed(imm_i[13:0])) * 4;
        tgt = aa_i ? 64'(sdisp) : cia + 64'(sdisp);
        if (is_lr) tgt = {m_lr[63:2], 2'b00};
        if (is_cc) tgt = {m_ctr[63:2], 2'b00};
        if (!is64Bit_i) tgt[63:32] = 32'h0;
        dec     = (is_bc || is_lr) && !bo_i[2];
        ctrm1   = m_ctr - 64'd1;
        zero    = is64Bit_i ? (ctrm1 == 64'd0) : (ctrm1[31:0] == 32'd0);
        ctr_ok  = is_cc || bo_i[2] || ((!zero) != bo_i[1]);
        cond_ok = bo_i[4] || (m_cr[31 - int'(bi_i)] == bo_i[3]);
        tk      = is_b || ((is_bc || is_lr || is_cc) && ctr_ok && cond_ok);
        if (is_br && lk_i) new_lr = is64Bit_i ? nia : {32'h0, nia[31:0]};
        if (dec) new_ctr = ctrm1;
        e.br  = tk;
        e.pc  = tk ? tgt : nia;
        e.lr  = new_lr;
        e.ctr = new_ctr;
        m_pc  = e.pc;
        exp_q.push_back(e);
      end
      m_lr  = new_lr;
      m_ctr = new_ctr;
      if (crWrite_i) m_cr = crData_i;
    end
    @(posedge clock_i);
    #1;
    valid_i = 1'b0; stall_i = 1'b0; is64Bit_i = 1'b1;
    crWrite_i = 1'b0; lrWrite_i = 1'b0; ctrWrite_i = 1'b0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [9:0] xop, input logic [4:0] bo,
                       input logic [4:0] bi, input logic [23:0] imm, input logic aa,
                       input logic lk, input logic [63:0] cia, input logic m64);
    opCode_i = op; xOpCode_i = xop; bo_i = bo; bi_i = bi; imm_i = imm;
    aa_i = aa; lk_i = lk; instructionAddress_i = cia; is64Bit_i = m64; valid_i = 1'b1;
    cycle();
  endtask

  task automatic spr_write(input logic lw, input logic cw, input logic [63:0] data,
                           input logic cw_cr, input logic [31:0] crd);
    lrWrite_i = lw; ctrWrite_i = cw; sprData_i = data; crWrite_i = cw_cr; crData_i = crd;
    cycle();
  endtask

  task automatic apply_reset();
    reset_i = 1'b0;
    #1;
    exp_q.delete();
    m_lr = '0; m_ctr = '0; m_cr = '0; m_pc = RV;
    chk("reset_pc", PC_o, RV);
    chk("reset_valid", 64'(valid_o), 64'd0);
    chk("reset_branching", 64'(isBranching_o), 64'd0);
    chk("reset_lr", lr_o, 64'd0);
    chk("reset_ctr", ctr_o, 64'd0);
    #2;
    reset_i = 1'b1;
  endtask

  task automatic rand_phase(input int n);
    logic [5:0] op;
    logic [9:0] xop;
    int         sel;
    for (int k = 0; k < n; k++) begin
      sel = int'($urandom_range(0, 4));
      xop = 10'($urandom);
      case (sel)
        0: op = 6'd18;
        1: op = 6'd16;
        2: begin op = 6'd19; xop = 10'd16; end
        3: begin op = 6'd19; xop = 10'd528; end
        default: op = 6'($urandom);
      endcase
      opCode_i = op; xOpCode_i = xop;
      bo_i = 5'($urandom); bi_i = 5'($urandom); imm_i = 24'($urandom);
      aa_i = ($urandom_range(0, 3) == 0); lk_i = 1'($urandom);
      instructionAddress_i = {$urandom, $urandom} & ~64'h3;
      is64Bit_i = ($urandom_range(0, 2) != 0);
      crWrite_i = ($urandom_range(0, 3) == 0); crData_i = $urandom;
      lrWrite_i = ($urandom_range(0, 5) == 0); ctrWrite_i = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 2))
        0:       sprData_i = 64'($urandom_range(0, 3));
        1:       sprData_i = {$urandom, 32'h1};
        default: sprData_i = {$urandom, $urandom};
      endcase
      stall_i = ($urandom_range(0, 7) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      cycle();
    end
  endtask

  initial begin
    @(posedge clock_i);
    #1;
    apply_reset();
    mon_en = 1'b1;

    issue(6'd18, 10'd0, 5'b00000, 5'd0, 24'hFFFFFC, 1'b0, 1'b1, 64'h100, 1'b1);
    chk("b_pc", PC_o, 64'hF0);
    chk("b_taken", 64'(isBranching_o), 64'd1);
    chk("b_lr", lr_o, 64'h104);

    spr_write(1'b0, 1'b1, 64'd2, 1'b0, 32'h0);
    chk("hold_pc", PC_o, 64'hF0);
    chk("spr_valid", 64'(valid_o), 64'd0);
    issue(6'd16, 10'd0, 5'b10000, 5'd0, 24'd8, 1'b0, 1'b0, 64'h200, 1'b1);
    chk("bc_ctr_pc", PC_o, 64'h220);
    chk("bc_ctr_ctr", ctr_o, 64'd1);
    issue(6'd16, 10'd0, 5'b10000, 5'd0, 24'd8, 1'b0, 1'b0, 64'h200, 1'b1);
    chk("bc_ctr0_pc", PC_o, 64'h204);
    chk("bc_ctr0_taken", 64'(isBranching_o), 64'd0);
    chk("bc_ctr0_ctr", ctr_o, 64'd0);

    spr_write(1'b0, 1'b0, 64'd0, 1'b1, 32'h8000_0000);
    issue(6'd16, 10'd0, 5'b01100, 5'd0, 24'd4, 1'b0, 1'b0, 64'h300, 1'b1);
    chk("bc_cr0_pc", PC_o, 64'h310);
    issue(6'd16, 10'd0, 5'b01100, 5'd1, 24'd4, 1'b0, 1'b0, 64'h300, 1'b1);
    chk("bc_cr1_pc", PC_o, 64'h304);

    spr_write(1'b0, 1'b1, 64'h1_0000_0001, 1'b0, 32'h0);
    issue(6'd16, 10'd0, 5'b10010, 5'd0, 24'h10, 1'b0, 1'b0, 64'hFFFF_FFFF_0000_0400, 1'b0);
    chk("m32_pc", PC_o, 64'h440);
    chk("m32_taken", 64'(isBranching_o), 64'd1);
    chk("m32_ctr", ctr_o, 64'h1_0000_0000);

    spr_write(1'b0, 1'b1, 64'd10, 1'b0, 32'h0);
    ctrWrite_i = 1'b1; sprData_i = 64'd5;
    issue(6'd16, 10'd0, 5'b10000, 5'd0, 24'd2, 1'b0, 1'b0, 64'h700, 1'b1);
    chk("ctr_conflict", ctr_o, 64'd9);
    spr_write(1'b0, 1'b1, 64'h203, 1'b0, 32'h0);
    issue(6'd19, 10'd528, 5'b10000, 5'd0, 24'd0, 1'b0, 1'b0, 64'h800, 1'b1);
    chk("bcctr_pc", PC_o, 64'h200);
    chk("bcctr_ctr", ctr_o, 64'h203);

    spr_write(1'b1, 1'b0, 64'h507, 1'b0, 32'h0);
    issue(6'd19, 10'd16, 5'b10100, 5'd0, 24'd0, 1'b0, 1'b1, 64'h600, 1'b1);
    chk("bclr_pc", PC_o, 64'h504);
    chk("bclr_lr", lr_o, 64'h604);

    stall_i = 1'b1; ctrWrite_i = 1'b1; sprData_i = 64'h77; crWrite_i = 1'b1;
    issue(6'd18, 10'd0, 5'b00000, 5'd0, 24'd64, 1'b1, 1'b1, 64'hA00, 1'b1);
    chk("stall_valid", 64'(valid_o), 64'd0);
    chk("stall_pc", PC_o, 64'h504);
    chk("stall_lr", lr_o, 64'h604);
    chk("stall_ctr", ctr_o, 64'h203);

    issue(6'd31, 10'd16, 5'b10100, 5'd0, 24'd0, 1'b0, 1'b1, 64'h900, 1'b1);
    chk("nonbranch_pc", PC_o, 64'h904);
    chk("nonbranch_lr", lr_o, 64'h604);

    rand_phase(400);

    issue(6'd18, 10'd0, 5'b00000, 5'd0, 24'd4, 1'b0, 1'b1, 64'hB00, 1'b1);
    apply_reset();
    issue(6'd18, 10'd0, 5'b00000, 5'd0, 24'h40, 1'b1, 1'b0, 64'h50, 1'b1);
    chk("resume_pc", PC_o, 64'h100);
    chk("resume_valid", 64'(valid_o), 64'd1);

    rand_phase(100);
    cycle();
    cycle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_exec_unit.md
BRANCH_EXEC_UNIT -- requirements
Module: branch_exec_unit

Interface
REQ-001 SHALL have parameter addressWidth, default 64, width of PC/LR/CTR/target.
REQ-002 SHALL have parameter immWidth, default 24, width of imm_i (LI field).
REQ-003 SHALL have parameter resetVector, default 0, PC_o value after reset.
REQ-004 SHALL have parameters opcodeWidth 6 and xOpCodeWidth 10, the primary and extended opcode widths.
REQ-005 SHALL have ports, in this order (name, direction, width, meaning):
- clock_i  in  1  sole clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- stall_i  in  1  1 = hold all state and outputs.
- valid_i  in  1  instruction present.
- is64Bit_i  in  1  1 = 64-bit mode, 0 = 32-bit mode.
- opCode_i  in  opcodeWidth  primary opcode.
- xOpCode_i  in  xOpCodeWidth  XL extended opcode.
- imm_i  in  immWidth  LI for I-form; BD in the low 14 bits for B-form.
- bo_i  in  5  BO field; bit 0 is the MSB.
- bi_i  in  5  CR bit index.
- aa_i, lk_i  in  1 each  AA and LK bits.
- instructionAddress_i  in  addressWidth  CIA.
- crWrite_i  in  1  load CR from crData_i.
- crData_i  in  32  CR write data.
- lrWrite_i, ctrWrite_i  in  1 each  mtspr LR/CTR strobes.
- sprData_i  in  addressWidth  mtspr data.
- valid_o  out  1  result valid.
- isBranching_o  out  1  taken; flush request.
- PC_o  out  addressWidth  next fetch address.
- lr_o, ctr_o  out  addressWidth each  current LR and CTR.

Function
REQ-006 SHALL accept an instruction in every cycle where valid_i=1 and stall_i=0; latency is exactly 1 cycle (outputs registered).
REQ-007 SHALL decode: b = opCode 18; bc = opCode 16; bclr = opCode 19 with xOp 16; bcctr = opCode 19 with xOp 528; any other accepted instruction is a non-branch.
REQ-008 SHALL sign-extend the displacement as (imm<<2): LI for b, BD for bc. Target = displacement if aa_i=1, else CIA + displacement. bclr target = LR with bits [1:0] cleared; bcctr target = CTR with bits [1:0] cleared.
REQ-009 SHALL follow Power ISA BO semantics: if bo[2]=0, CTR decrements by 1 (modulo 2^addressWidth); ctr_ok = bo[2] | ((CTR-1 != 0) XOR bo[3]); cond_ok = bo[0] | (CR[bi] == bo[1]); taken = ctr_ok & cond_ok. CR bit 0 is the MSB of crData.
REQ-010 SHALL ignore bo[2] for bcctr: no decrement, ctr_ok = 1.
REQ-011 SHALL treat b as unconditionally taken.
REQ-012 SHALL, in 32-bit mode, test only bits [31:0] of CTR-1 for zero, and zero the upper addressWidth-32 bits of the target and of the LR write value.
REQ-013 SHALL, when lk_i=1 on any branch, write LR = CIA+4; bclr uses the pre-update LR as its target.
REQ-014 SHALL drive valid_o=1 for one cycle per accepted instruction, and 0 otherwise.
REQ-015 SHALL, when taken, set PC_o = target and isBranching_o = 1; otherwise PC_o = CIA+4 and isBranching_o = 0.
REQ-016 SHALL hold PC_o, lr_o and ctr_o between results; isBranching_o SHALL be 1 only while valid_o=1.
REQ-017 SHALL apply crWrite_i/lrWrite_i/ctrWrite_i at the clock edge when stall_i=0, with or without valid_i.
REQ-018 SHALL, when an SPR write and a branch update the same register in the same cycle, let the branch update win; CR writes are visible to the next instruction, not the current one.
REQ-019 SHALL freeze all state when stall_i=1, with valid_o forced to 0 and SPR writes ignored.

Reset
REQ-020 SHALL, on reset_i=0 (asynchronous, including mid-operation), force PC_o=resetVector, valid_o=0, isBranching_o=0, LR=0, CTR=0, CR=0.
REQ-021 SHALL resume accepting instructions on the first rising edge after reset_i returns to 1.

Verification
REQ-022 SHALL cover: b with CIA=0x100, LI=-4, aa=0, lk=1 -> next cycle PC_o=0xF0, isBranching_o=1, lr_o=0x104.
REQ-023 SHALL cover: CTR=2, bc with BO=10000, BD=8 -> PC_o=CIA+0x20 taken, ctr_o=1; repeat -> not taken, PC_o=CIA+4, ctr_o=0.
REQ-024 SHALL cover: crData=0x80000000, bc with BO=01100, bi=0 -> taken; with bi=1 -> not taken.
REQ-025 SHALL cover: 32-bit mode, CTR=0x1_00000001, bc with BO=10010 -> CTR-1 low word is 0, so taken; upper target bits are 0.
REQ-026 SHALL cover: ctrWrite_i with sprData=5 in the same cycle as a decrementing bc -> ctr_o = old CTR-1; bcctr with CTR=0x203 -> PC_o=0x200.
REQ-027 SHALL cover: stall_i=1 with valid_i=1 -> valid_o=0 and state unchanged; reset_i low mid-stream -> PC_o=resetVector immediately.
